// File: rtl/rom_read_sequencer.sv
// Streams a run of consecutive ROM words onto a valid/ready bus. A 2-entry skid buffer
// absorbs the ROM's one-cycle read latency so that backpressure never drops a word.
module rom_read_sequencer #(
    parameter int ROM_DEPTH = 1024,
    parameter int NUM_DATA  = 1,
    parameter int BIT_WIDTH = 16,
    localparam int AW = $clog2(ROM_DEPTH),
    localparam int DW = NUM_DATA * BIT_WIDTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   num_words,
    output logic          busy,
    output logic          done,
    output logic          rom_cen,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_q,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t        state, state_next;
    logic [AW-1:0] addr;
    logic [AW:0]   issue_left;
    logic [AW:0]   hs_left;
    logic          pend;
    logic [1:0]    cnt;
    logic [DW-1:0] buf_mem [2];
    logic          rd_ptr, wr_ptr;
    logic          issue, pop;
    logic [2:0]    occ_after;

    // A new read may only go out if the buffer will still have room for it once the
    // in-flight word lands, counting a word leaving through the output this cycle.
    assign pop       = out_valid & out_ready;
    assign occ_after = {1'b0, cnt} + {2'b0, pend} - {2'b0, pop};
    assign issue     = (state == RUN) && (occ_after < 3'd2);

    assign rom_cen   = ~issue;
    assign rom_addr  = addr;
    assign out_valid = (cnt != 2'd0);
    assign out_data  = buf_mem[rd_ptr];
    assign out_last  = out_valid && (hs_left == (AW+1)'(1));

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = (num_words == '0) ? DONE : RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (issue && issue_left == (AW+1)'(1)) state_next = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (pop && hs_left == (AW+1)'(1)) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr       <= '0;
            issue_left <= '0;
            hs_left    <= '0;
            pend       <= 1'b0;
            cnt        <= 2'd0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            for (int i = 0; i < 2; i++) buf_mem[i] <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && start) begin
                addr       <= base_addr;
                issue_left <= num_words;
                hs_left    <= num_words;
            end else begin
                if (issue) begin
                    addr       <= (addr == AW'(ROM_DEPTH - 1)) ? '0 : addr + AW'(1);
                    issue_left <= issue_left - (AW+1)'(1);
                end
                if (pop) hs_left <= hs_left - (AW+1)'(1);
            end
            pend <= issue;
            // rom_q is only meaningful the cycle after a read, so capture strictly on pend.
            if (pend) begin
                buf_mem[wr_ptr] <= rom_q;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            cnt <= cnt + {1'b0, pend} - {1'b0, pop};
        end
    end

endmodule
